// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer for the MIPS core.
// Chooses the next PC each retired fetch and buffers redirects that arrive while a fetch is outstanding.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_addr,
    input  logic        exc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect_pending,
    output logic        addr_err
);

    typedef enum logic [1:0] {BOOT, FETCH, PEND} state_t;

    // Redirect ranks: higher wins, and a buffered redirect yields to an equal or higher rank.
    localparam logic [1:0] RANK_BRANCH = 2'd0;
    localparam logic [1:0] RANK_JUMP   = 2'd1;
    localparam logic [1:0] RANK_JR     = 2'd2;
    localparam logic [1:0] RANK_EXC    = 2'd3;

    state_t      state, stateNext;
    logic [31:0] pcNext;
    logic [31:0] pendTarget, pendTargetNext;
    logic [1:0]  pendRank, pendRankNext;
    logic        addrErrNext;

    logic        redirValid;
    logic        redirMisaligned;
    logic [1:0]  redirRank;
    logic [31:0] redirTarget;
    logic        advance;
    logic        takeNew;

    assign pc_plus4         = pc + 32'd4;
    assign fetch_addr       = pc;
    assign fetch_req        = (state != BOOT);
    assign redirect_pending = (state == PEND);
    assign advance          = fetch_ack && !stall;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        redirValid      = exc || jump_reg || jump || branch_taken;
        redirMisaligned = 1'b0;
        redirRank       = RANK_BRANCH;
        redirTarget     = pc_plus4 + (branch_imm << 2);
        if (exc) begin
            redirRank   = RANK_EXC;
            redirTarget = EXC_VECTOR;
        end else if (jump_reg) begin
            redirRank       = RANK_JR;
            redirMisaligned = (jr_addr[1:0] != 2'b00);
            redirTarget     = redirMisaligned ? EXC_VECTOR : jr_addr;
        end else if (jump) begin
            redirRank   = RANK_JUMP;
            redirTarget = {pc_plus4[31:28], jump_index, 2'b00};
        end
    end

    assign takeNew = redirValid && (redirRank >= pendRank);

    always_comb begin
        stateNext      = state;
        pcNext         = pc;
        pendTargetNext = pendTarget;
        pendRankNext   = pendRank;
        addrErrNext    = 1'b0;
        case (state)
            BOOT: stateNext = FETCH;
            FETCH: begin
                if (advance) begin
                    pcNext      = redirValid ? redirTarget : pc_plus4;
                    addrErrNext = redirValid && redirMisaligned;
                end else if (redirValid) begin
                    pendTargetNext = redirTarget;
                    pendRankNext   = redirRank;
                    addrErrNext    = redirMisaligned;
                    stateNext      = PEND;
                end
            end
            PEND: begin
                if (takeNew) begin
                    pendTargetNext = redirTarget;
                    pendRankNext   = redirRank;
                    addrErrNext    = redirMisaligned;
                end
                if (advance) begin
                    pcNext         = takeNew ? redirTarget : pendTarget;
                    pendTargetNext = '0;
                    pendRankNext   = RANK_BRANCH;
                    stateNext      = FETCH;
                end
            end
            default: stateNext = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            pendTarget <= '0;
            pendRank   <= RANK_BRANCH;
            addr_err   <= 1'b0;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            pendTarget <= pendTargetNext;
            pendRank   <= pendRankNext;
            addr_err   <= addrErrNext;
        end
    end

endmodule
